clock_enable_ctrl: RTL and testbench

Sequencer for the SAP-1 master clock enable. Generates `mclk_en` for every other block from one of three sources: free-running divided enable (run), single debounced push-button step (step), or forced stop on the CPU halt signal. Replaces the constant-high enable on FPGA builds and lets simulation exercise step and halt behaviour.

---
 rtl/clk_ctrl_pkg.sv | 15 +
 rtl/button_debounce.sv | 32 +++
 rtl/clock_enable_ctrl.sv | 129 ++++++++++++
 tb/tb_clock_enable_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the SAP-1 master clock-enable sequencer.
// The state encoding is exported on state_o, so the values here are fixed.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } clk_state_e;

    localparam int DEFAULT_DIV_W           = 24;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/button_debounce.sv
// Level debouncer for an already-synchronized push-button.
// dout follows din only after CYCLES consecutive samples that differ from
// the current dout; any sample equal to dout restarts the count.
module button_debounce #(
    parameter int CYCLES = 16
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count disagreeing samples; commit the new level on the CYCLES-th one.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dout  <= 1'b0;
        end else if (din == dout) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
            cnt_q <= '0;
            dout  <= din;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clock_enable_ctrl.sv
// Master clock-enable sequencer: run (divided), single step, and halt.
// Optional debouncer on the step button: define CLOCK_ENABLE_DEBOUNCE_EN.
// mclk_en, state_o and halted are decoded from registers only, so reset
// drops them asynchronously and no input reaches them combinationally.
module clock_enable_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W           = DEFAULT_DIV_W,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             run_mode,
    input  logic             step_btn,
    input  logic             halt,
    input  logic             resume,
    input  logic [DIV_W-1:0] div_val,
    output logic             mclk_en,
    output logic [1:0]       state_o,
    output logic             halted
);

    logic             sync_q1;
    logic             sync_q2;
    logic             btn_level;
    logic             btn_prev_q;
    logic             step_evt;
    clk_state_e       state_q;
    clk_state_e       state_d;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= step_btn;
            sync_q2 <= sync_q1;
        end
    end

`ifdef CLOCK_ENABLE_DEBOUNCE_EN
    button_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .mclk  (mclk),
        .rst_n (rst_n),
        .din   (sync_q2),
        .dout  (btn_level)
    );
`else
    // DEBOUNCE_CYCLES only matters when the debouncer is built.
    logic debounce_cycles_unused;
    assign debounce_cycles_unused = (DEBOUNCE_CYCLES > 0);
    assign btn_level = sync_q2;
`endif

    // Previous button level for rising-edge detection (one event per press).
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= 1'b0;
        end else begin
            btn_prev_q <= btn_level;
        end
    end

    assign step_evt = btn_level & ~btn_prev_q;

    // State and divider registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and divider logic; halt overrides every state last.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Run wins over a coincident step, which is dropped.
                if (run_mode) begin
                    state_d = ST_RUN;
                    cnt_d   = div_val;
                end else if (step_evt) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                // A new div_val only lands at the next reload.
                cnt_d = (cnt_q == '0) ? div_val : cnt_q - DIV_W'(1);
                if (!run_mode) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (run_mode) begin
                    state_d = ST_RUN;
                    cnt_d   = div_val;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (halt) begin
            state_d = ST_HALTED;
        end
    end

    assign mclk_en = (state_q == ST_STEP) || ((state_q == ST_RUN) && (cnt_q == '0));
    assign state_o = state_q;
    assign halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_clock_enable_ctrl.sv
// Self-checking bench for clock_enable_ctrl. Expected {halted, state_o,
// mclk_en} words are pushed to exp_q as stimulus is driven and popped one
// cycle later, #1 after the rising edge. Build with CLOCK_ENABLE_DEBOUNCE_EN
// to add the debouncer latency and the debounced-step scenario.
module tb_clock_enable_ctrl;

    localparam int DIV_W = 8;
    localparam int DBC   = 4;
`ifdef CLOCK_ENABLE_DEBOUNCE_EN
    localparam int DB_LAT = DBC;
`else
    localparam int DB_LAT = 0;
`endif
    // Edge index (counted from the first edge after the press) that enters STEP.
    localparam int STEP_AT = 2 + DB_LAT;

    logic             mclk;
    logic             rst_n;
    logic             run_mode;
    logic             step_btn;
    logic             halt;
    logic             resume;
    logic [DIV_W-1:0] div_val;
    logic             mclk_en;
    logic [1:0]       state_o;
    logic             halted;

    logic [3:0] exp_q[$];
    int         checks;
    int         errors;

    clock_enable_ctrl #(
        .DIV_W           (DIV_W),
        .DEBOUNCE_CYCLES (DBC)
    ) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .run_mode (run_mode),
        .step_btn (step_btn),
        .halt     (halt),
        .resume   (resume),
        .div_val  (div_val),
        .mclk_en  (mclk_en),
        .state_o  (state_o),
        .halted   (halted)
    );

    // Clock and reset.
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic test_reset;
        logic [3:0] got;
        logic [3:0] exp;
        rst_n    = 1'b0;
        run_mode = 1'b1;
        step_btn = 1'b0;
        halt     = 1'b0;
        resume   = 1'b0;
        div_val  = 8'd3;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4'b0000);
            @(posedge mclk); #1;
            got = {halted, state_o, mclk_en};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        rst_n = 1'b1;
        // First edge after release enters RUN with cnt=3.
        exp_q.push_back(4'b0010);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_run_entry got=%b exp=%b", got, exp);
        end
        run_mode = 1'b0;
        exp_q.push_back(4'b0000);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_to_idle got=%b exp=%b", got, exp);
        end
    endtask

    // Run mode for 20 cycles; div_val switches from dv0 to dv1 before edge chg.
    task automatic test_run_divide(input int dv0, input int dv1, input int chg);
        logic [3:0] got;
        logic [3:0] exp;
        logic       en_exp;
        int         nxt;
        div_val  = DIV_W'(dv0);
        run_mode = 1'b1;
        nxt      = dv0;
        for (int k = 0; k < 20; k++) begin
            if (k == chg) div_val = DIV_W'(dv1);
            en_exp = (k == nxt);
            if (en_exp) nxt = k + 1 + ((k + 1 >= chg) ? dv1 : dv0);
            exp_q.push_back({1'b0, 2'd1, en_exp});
            @(posedge mclk); #1;
            got = {halted, state_o, mclk_en};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL run_divide dv=%0d/%0d k=%0d got=%b exp=%b", dv0, dv1, k, got, exp);
            end
        end
        run_mode = 1'b0;
        exp_q.push_back(4'b0000);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL run_exit got=%b exp=%b", got, exp);
        end
    endtask

    // Hold the button 50 cycles: exactly one STEP cycle.
    task automatic test_step;
        logic [3:0] got;
        logic [3:0] exp;
        int         pulses;
        run_mode = 1'b0;
        pulses   = 0;
        for (int k = 0; k < 64; k++) begin
            step_btn = (k < 50);
            exp_q.push_back((k == STEP_AT) ? 4'b0101 : 4'b0000);
            @(posedge mclk); #1;
            got = {halted, state_o, mclk_en};
            if (mclk_en === 1'b1) pulses++;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL step k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL step_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_halt;
        logic [3:0] got;
        logic [3:0] exp;
        div_val  = 8'd0;
        run_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4'b0011);
            @(posedge mclk); #1;
            got = {halted, state_o, mclk_en};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL halt_run k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        halt = 1'b1;
        exp_q.push_back(4'b1110);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL halt_enter got=%b exp=%b", got, exp);
        end
        halt = 1'b0;
        // Button presses and run_mode toggles are ignored while halted.
        for (int k = 0; k < 16; k++) begin
            step_btn = (k >= 2) && (k < 6);
            run_mode = k[0];
            exp_q.push_back(4'b1110);
            @(posedge mclk); #1;
            got = {halted, state_o, mclk_en};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL halt_hold k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        run_mode = 1'b0;
        resume   = 1'b1;
        halt     = 1'b1;
        exp_q.push_back(4'b1110);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL resume_with_halt got=%b exp=%b", got, exp);
        end
        halt = 1'b0;
        exp_q.push_back(4'b0000);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL resume got=%b exp=%b", got, exp);
        end
        resume = 1'b0;
        exp_q.push_back(4'b0000);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL after_resume got=%b exp=%b", got, exp);
        end
    endtask

    // step_evt and run_mode together in IDLE, then halt with run_mode=0 in RUN.
    task automatic test_simultaneous;
        logic [3:0] got;
        logic [3:0] exp;
        run_mode = 1'b0;
        div_val  = 8'd2;
        for (int k = 0; k < STEP_AT + 6; k++) begin
            step_btn = (k < STEP_AT + 3);
            if (k == STEP_AT) run_mode = 1'b1;
            if (k < STEP_AT) exp_q.push_back(4'b0000);
            else             exp_q.push_back({1'b0, 2'd1, ((k - STEP_AT) % 3) == 2});
            @(posedge mclk); #1;
            got = {halted, state_o, mclk_en};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simul_run_step k=%0d got=%b exp=%b", k, got, exp);
            end
        end
        halt     = 1'b1;
        run_mode = 1'b0;
        exp_q.push_back(4'b1110);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL simul_halt got=%b exp=%b", got, exp);
        end
        halt   = 1'b0;
        resume = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(4'b0000);
            @(posedge mclk); #1;
            resume = 1'b0;
            got = {halted, state_o, mclk_en};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simul_resume k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    // Reset asserted mid-cycle while mclk_en is high drops it without an edge.
    task automatic test_async_reset;
        logic [3:0] got;
        logic [3:0] exp;
        div_val  = 8'd0;
        run_mode = 1'b1;
        exp_q.push_back(4'b0011);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_pre got=%b exp=%b", got, exp);
        end
        #2;
        exp_q.push_back(4'b0000);
        rst_n = 1'b0;
        #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_drop got=%b exp=%b", got, exp);
        end
        run_mode = 1'b0;
        @(posedge mclk); #1;
        rst_n = 1'b1;
        exp_q.push_back(4'b0000);
        @(posedge mclk); #1;
        got = {halted, state_o, mclk_en};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_release got=%b exp=%b", got, exp);
        end
    endtask

`ifdef CLOCK_ENABLE_DEBOUNCE_EN
    // Toggling every 2 cycles never survives a 4-sample debounce; stable does.
    task automatic test_debounce;
        logic [3:0] got;
        logic [3:0] exp;
        int         pulses;
        run_mode = 1'b0;
        pulses   = 0;
        exp_q.push_back(4'd0);
        for (int k = 0; k < 16; k++) begin
            step_btn = ((k / 2) % 2) == 0;
            @(posedge mclk); #1;
            if (mclk_en === 1'b1) pulses++;
        end
        got = 4'(pulses);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL debounce_toggle got=%0d exp=%0d", got, exp);
        end
        pulses = 0;
        exp_q.push_back(4'd1);
        for (int k = 0; k < 12; k++) begin
            step_btn = 1'b1;
            @(posedge mclk); #1;
            if (mclk_en === 1'b1) pulses++;
        end
        step_btn = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge mclk); #1;
            if (mclk_en === 1'b1) pulses++;
        end
        got = 4'(pulses);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL debounce_stable got=%0d exp=%0d", got, exp);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run_divide(3, 3, 1000);
        test_run_divide(0, 0, 1000);
        test_run_divide(3, 1, 2);
        test_step();
        test_halt();
        test_simultaneous();
        test_async_reset();
`ifdef CLOCK_ENABLE_DEBOUNCE_EN
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
